// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage register: control-bundle
// layout and the skid-buffer occupancy states.
package pipe_pkg;

  localparam int CTRL_W = 22;

  // Control bundle bit offsets (LSB first)
  localparam int CTRL_MEMWRITE = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_MEMTOREG = 5;   // [6:5]
  localparam int CTRL_ALUOP    = 7;   // [9:7]
  localparam int CTRL_JUMP     = 10;
  localparam int CTRL_SD       = 11;
  localparam int CTRL_LD       = 12;
  localparam int CTRL_BNE      = 13;
  localparam int CTRL_WMASK    = 14;  // [21:14]

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_st_t;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Upstream/downstream handshake bundle of one pipeline stage; the stage uses
// the slave view, whatever drives and consumes it uses the master view.
interface pipe_stage_hs_if #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry skid datapath: registered in_ready, outputs always from the main
// register, so nothing downstream reaches any output combinationally.
//   state    | meaning
//   ST_EMPTY | no beat held
//   ST_ONE   | one beat in main register
//   ST_TWO   | main and skid both held, in_ready low
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 192,
  parameter int CTRL_W = 22
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  stage_st_t         state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              rdy_q, rdy_d;
  logic              acc, drn;

  assign acc = in_valid_i & rdy_q;
  assign drn = (state_q != ST_EMPTY) & out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      // data registers hold; only control is scrubbed to a bubble
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          state_d     = ST_ONE;
          main_data_d = in_data_i;
          main_ctrl_d = in_ctrl_i;
        end
        ST_ONE: begin
          if (acc && !drn) begin
            state_d     = ST_TWO;
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end else if (drn && !acc) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end else if (acc && drn) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end
        end
        ST_TWO: if (drn) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = '0;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    rdy_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_q       <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_ctrl_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional two-entry skid and a saturating backpressure counter.
module pipe_stage_hs #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            nrst,
  pipe_stage_hs_if.slave bus
);

  logic             out_valid_w;
  logic [CNT_W-1:0] stall_q, stall_d;

  if (SKID == 0) begin : g_reg
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              rdy, acc;

    assign rdy = !valid_q | bus.out_ready;
    assign acc = bus.in_valid & rdy;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (bus.flush) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (acc) begin
        valid_d = 1'b1;
        data_d  = bus.in_data;
        ctrl_d  = bus.in_ctrl;
      end else if (valid_q && bus.out_ready) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ctrl_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        ctrl_q  <= ctrl_d;
      end
    end

    assign bus.in_ready = rdy;
    assign out_valid_w  = valid_q;
    assign bus.out_data = data_q;
    assign bus.out_ctrl = ctrl_q;
  end else begin : g_skid
    pipe_skid_buf #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk         (clk),
      .nrst        (nrst),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (bus.in_ready),
      .in_data_i   (bus.in_data),
      .in_ctrl_i   (bus.in_ctrl),
      .flush_i     (bus.flush),
      .out_valid_o (out_valid_w),
      .out_ready_i (bus.out_ready),
      .out_data_o  (bus.out_data),
      .out_ctrl_o  (bus.out_ctrl)
    );
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_w && !bus.out_ready && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign bus.out_valid = out_valid_w;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: SKID=0, SKID=1 and a 4-bit-counter SKID=0 instance
// share one stimulus stream; each has its own queue-based scoreboard.
module tb_pipe_stage_hs;

  localparam int DW  = 192;
  localparam int CTW = 22;
  localparam int ND  = 3;

  typedef struct {
    logic [DW-1:0]  data;
    logic [CTW-1:0] ctrl;
  } beat_t;

  typedef struct {
    bit iv, ordy, fl;
    bit exp_ov, exp_ir;
    int exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic nrst;
  logic           in_valid, flush, out_ready;
  logic [DW-1:0]  in_data;
  logic [CTW-1:0] in_ctrl;

  logic           rdy [ND];
  logic           ov  [ND];
  logic [DW-1:0]  od  [ND];
  logic [CTW-1:0] oc  [ND];
  logic [15:0]    st  [ND];

  int n_cmp = 0;
  int n_err = 0;

  beat_t sbq [ND][$];
  int    stall_exp [ND];
  int    n_out [ND];
  bit    rdy_exp1;
  int    sink1 [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int SK = (k == 1) ? 1 : 0;
    localparam int CW = (k == 2) ? 4 : 16;
    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CTW), .CNT_W(CW)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.in_ctrl   = in_ctrl;
    assign bus.flush     = flush;
    assign bus.out_ready = out_ready;
    assign rdy[k] = bus.in_ready;
    assign ov[k]  = bus.out_valid;
    assign od[k]  = bus.out_data;
    assign oc[k]  = bus.out_ctrl;
    assign st[k]  = 16'(bus.stall_cnt);
    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CTW), .SKID(SK), .CNT_W(CW)) u_dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
    );
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks current outputs against the model, then advances the model to the
  // state it should have after the coming rising edge.
  task automatic mon_step();
    for (int k = 0; k < ND; k++) begin
      bit mv, drn, acc;
      int smax;
      beat_t b;
      mv   = (sbq[k].size() > 0);
      smax = (k == 2) ? 15 : 65535;
      chk($sformatf("dut%0d out_valid", k), ov[k], mv);
      if (!ov[k]) chk($sformatf("dut%0d bubble ctrl", k), oc[k], '0);
      if (k == 1) chk("dut1 in_ready", rdy[k], rdy_exp1);
      else        chk($sformatf("dut%0d in_ready", k), rdy[k], !mv || out_ready);
      chk($sformatf("dut%0d stall_cnt", k), st[k], stall_exp[k]);
      drn = mv && out_ready;
      acc = in_valid && rdy[k];
      if (drn) begin
        b = sbq[k].pop_front();
        chk($sformatf("dut%0d out_data", k), od[k], b.data);
        chk($sformatf("dut%0d out_ctrl", k), oc[k], b.ctrl);
        n_out[k]++;
        if (k == 1) sink1.push_back(int'(od[k][31:0]));
      end
      if (mv && !out_ready && stall_exp[k] < smax) stall_exp[k]++;
      if (flush) sbq[k].delete();
      else if (acc) begin
        b.data = in_data;
        b.ctrl = in_ctrl;
        sbq[k].push_back(b);
      end
      if (k == 1) rdy_exp1 = (sbq[1].size() < 2);
    end
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < ND; k++) begin
        sbq[k].delete();
        stall_exp[k] = 0;
      end
      rdy_exp1 = 1'b1;
    end else begin
      mon_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s dut%0d out_valid", tag, k), ov[k], 1'b0);
      chk($sformatf("%s dut%0d out_data", tag, k), od[k], '0);
      chk($sformatf("%s dut%0d out_ctrl", tag, k), oc[k], '0);
      chk($sformatf("%s dut%0d stall_cnt", tag, k), st[k], '0);
      chk($sformatf("%s dut%0d in_ready", tag, k), rdy[k], 1'b1);
    end
  endtask

  vec_t vec [16];
  int   exp_sink [$];

  initial begin
    vec[0]  = '{1, 1, 0, 1, 1, 0};
    vec[1]  = '{1, 0, 0, 1, 0, 1};
    vec[2]  = '{1, 0, 0, 1, 0, 2};
    vec[3]  = '{1, 0, 0, 1, 0, 3};
    vec[4]  = '{1, 0, 0, 1, 0, 4};
    vec[5]  = '{1, 0, 0, 1, 0, 5};
    vec[6]  = '{1, 1, 0, 1, 1, 5};
    vec[7]  = '{1, 1, 0, 1, 1, 5};
    vec[8]  = '{0, 1, 0, 0, 1, 5};
    vec[9]  = '{1, 0, 0, 1, 1, 5};
    vec[10] = '{1, 0, 0, 1, 0, 6};
    vec[11] = '{1, 0, 1, 0, 1, 7};   // flush while two beats held
    vec[12] = '{1, 1, 0, 1, 1, 7};
    vec[13] = '{1, 1, 1, 0, 1, 7};   // flush + accept + drain together
    vec[14] = '{1, 1, 0, 1, 1, 7};
    vec[15] = '{0, 1, 0, 0, 1, 7};

    for (int k = 0; k < ND; k++) n_out[k] = 0;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    nrst = 1'b1;
    step();

    // back-to-back stream with downstream always ready
    for (int i = 0; i < 100; i++) begin
      in_valid  = 1'b1;
      in_data   = DW'(i);
      in_ctrl   = 22'h3FFFFF;
      out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    in_data  = {6{$urandom}};
    in_ctrl  = CTW'($urandom);
    step();
    for (int k = 0; k < ND; k++)
      chk($sformatf("stream dut%0d beats out", k), DW'(n_out[k]), DW'(100));
    step();

    for (int r = 0; r < 16; r++) begin
      in_valid  = vec[r].iv;
      out_ready = vec[r].ordy;
      flush     = vec[r].fl;
      if (vec[r].iv) begin
        in_data = DW'(200 + r);
        in_ctrl = CTW'(22'h155555 ^ r);
      end else begin
        in_data = {6{$urandom}};
        in_ctrl = CTW'($urandom);
      end
      step();
      chk($sformatf("vec%0d skid out_valid", r), ov[1], vec[r].exp_ov);
      chk($sformatf("vec%0d skid in_ready", r), rdy[1], vec[r].exp_ir);
      chk($sformatf("vec%0d skid stall_cnt", r), st[1], DW'(vec[r].exp_stall));
    end
    flush = 1'b0;

    for (int i = 0; i < 100; i++) exp_sink.push_back(i);
    exp_sink.push_back(200);
    exp_sink.push_back(201);
    exp_sink.push_back(207);
    exp_sink.push_back(212);
    exp_sink.push_back(214);
    chk("skid sink length", DW'(sink1.size()), DW'(exp_sink.size()));
    for (int i = 0; i < exp_sink.size() && i < sink1.size(); i++)
      chk($sformatf("skid sink[%0d]", i), DW'(sink1[i]), DW'(exp_sink[i]));

    // counter saturation on the 4-bit instance
    in_valid  = 1'b1;
    in_data   = DW'(300);
    in_ctrl   = 22'h0ABCDE;
    out_ready = 1'b0;
    repeat (20) step();
    chk("sat stall_cnt after 20", st[2], DW'(15));
    repeat (5) step();
    chk("sat stall_cnt held", st[2], DW'(15));

    // asynchronous reset while beats are held
    for (int k = 0; k < ND; k++)
      chk($sformatf("pre-reset dut%0d out_valid", k), ov[k], 1'b1);
    #3;
    nrst = 1'b0;
    #1;
    check_reset_vals("async reset");
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    nrst = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline-stage register with a valid/ready handshake, flush-to-bubble and an optional skid buffer. It replaces the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RV64 pipeline. Stages can stall and be flushed independently, and backpressure is timing-isolated when required. Payload is split into a data bundle (ALU result, read data, PC, instruction) and a control bundle (MemWrite … wmask); only control is forced to zero on a bubble.

## Interface
- `DATA_W`, default 192: data bundle width (64 ALU result + 64 rdata + 32 PC + 32 inst).
- `CTRL_W`, default 22: control bundle width (`pipe_pkg::CTRL_W`).
- `SKID`, default 0: 0 = single register with combinational ready; 1 = two-entry skid with registered `in_ready`.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `nrst` in 1: reset; one clock, asynchronous, active-low.
- `in_valid` in 1: upstream presents a beat.
- `in_ready` out 1: stage can accept a beat.
- `in_data` in DATA_W: upstream data bundle.
- `in_ctrl` in CTRL_W: upstream control bundle.
- `flush` in 1: discard all held beats and the beat presented this cycle.
- `out_valid` out 1: beat held for downstream.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W: held data bundle.
- `out_ctrl` out CTRL_W: held control bundle; all-zero whenever `out_valid`=0.
- `stall_cnt` out CNT_W: saturating count of backpressured cycles.

## Operation
- Definitions: `acc = in_valid & in_ready`; `drn = out_valid & out_ready`.
- **SKID=0**
  - `in_ready = !out_valid | out_ready` (combinational).
  - On `acc`, the register loads in/ctrl and `out_valid` is set.
  - On `drn & !acc`, `out_valid` clears and `out_ctrl` is set to 0.
- **SKID=1** uses a main register plus a skid register. State is EMPTY / ONE / TWO.
  - EMPTY: `acc` → ONE (main loads input).
  - ONE:
    - `acc & !drn` → TWO (skid loads input).
    - `drn & !acc` → EMPTY.
    - `acc & drn` → ONE (main loads input).
  - TWO: `in_ready`=0. `drn` → ONE (main loads skid).
  - `in_ready` is registered and equals (next state != TWO).
  - Outputs always come from the main register. Beat order is preserved.
- **Flush** has priority over every other event.
  - Next state is EMPTY (or `out_valid`=0) and all `ctrl` registers are set to 0. Data registers hold.
  - A beat accepted in the flush cycle is dropped.
  - A `drn` in the flush cycle still counts as delivered downstream.
- **Stall counter**
  - Increments when `out_valid & !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- `in_data`/`in_ctrl` are ignored when `in_valid`=0. No X propagates into `out_ctrl` when invalid.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ctrl`=0, `stall_cnt`=0.
  - State is EMPTY.
  - `in_ready`=1 in both modes.
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat/cycle in both modes while `out_ready`=1.
- SKID=0: there is a combinational path `out_ready`→`in_ready`.
- SKID=1: there is no combinational path from `out_ready` to any output.
- When `out_ready` drops, one extra beat is absorbed into skid. `in_ready` falls at the next edge.
- Reset asserted mid-transfer: all beats are lost and outputs go to reset values immediately (asynchronous). Deassertion is synchronised externally.
- Simultaneous `flush` + `acc` + `drn`: the result is EMPTY. The downstream beat completes and the incoming beat is dropped.

## Structure
- `pipe_pkg` holds:
  - `CTRL_W`=22.
  - The bit offsets of MemWrite, RegWrite, Branch, MemRead, ALUSrc, MemToReg[1:0], ALUOp[2:0], Jump, sd, ld, bne, wmask[7:0].
  - The state enum `stage_st_t` {ST_EMPTY, ST_ONE, ST_TWO}.
- The SKID=1 datapath lives in sub-module `pipe_skid_buf`, selected by generate. The SKID=0 path is inline.

## Test plan
- **Reset:** assert `nrst`=0 mid-stream with `out_valid`=1 → `out_valid`=0, `out_ctrl`=0, `stall_cnt`=0 and `in_ready`=1 without waiting for a clock edge.
- **Streaming:** SKID=0 and SKID=1, 100 beats (`in_data` = beat index, `in_ctrl`=22'h3FFFFF) with `out_ready`=1 → 100 beats out in order, 1-cycle latency, no gaps.
- **Backpressure:** SKID=1, drop `out_ready` for 5 cycles while `in_valid`=1 → exactly 2 beats held, `in_ready`=0 from the second edge, `stall_cnt`=5, order intact after release.
- **Flush:** flush in state TWO with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1; neither held beat nor the incoming beat ever appears.
- **Flush during delivery:** flush and `drn` in the same cycle → the drained beat is counted once at the sink, and the next output is the first beat accepted after the flush.
- **Counter saturation:** CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt`=15 and it stays there.
